// File: rtl/instr_seq_pkg.sv
// instr_sequencer shared types: FSM states, instruction class codes
// and the class -> hold-cycle mapping.
package instr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    HOLD,
    FINISH
  } seq_state_e;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam int CNT_W = 8;

  function automatic int slot_cycles(
    input logic [1:0] cls,
    input int         std_c,
    input int         mem_c
  );
    int r;
    r = 0;
    case (cls)
      CLS_STD:   r = std_c;
      CLS_LOAD:  r = mem_c;
      CLS_STORE: r = mem_c;
      default:   r = 0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_prog_mem.sv
// Program store for instr_sequencer: synchronous write,
// asynchronous read.
module instr_prog_mem #(
  parameter int W  = 20,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [2**AW];

  // write port, one word per cycle
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps a stored program into simple_cpu, holding each word for its class slot.
// Optional INSTR_SEQ_STEP_EN: wait for step at the end of each slot.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4,
  parameter int STD_CYCLES     = 3,
  parameter int MEM_CYCLES     = 4,
  parameter int LEAD_CYCLES    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  input  logic [PROG_ADDR_BITS:0]   prog_len,
  input  logic                      start,
  input  logic                      step,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      busy,
  output logic                      done,
  output logic                      halted,
  output logic [PROG_ADDR_BITS:0]   pc
);

  localparam int AW = PROG_ADDR_BITS;
  localparam int LW = PROG_ADDR_BITS + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(2**AW);

  seq_state_e             state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   halted_q, halted_d;
  logic [LW-1:0]          pc_q, pc_d;
  logic [LW-1:0]          len_q, len_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [LW-1:0]          pc_inc;
  logic [LW-1:0]          len_clamp;
  logic [AW-1:0]          rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [1:0]             rd_cls;
  logic [1:0]             cur_cls;
  logic                   mem_we;
  logic                   adv;
  logic                   fin;

`ifdef INSTR_SEQ_STEP_EN
  assign adv = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign adv = 1'b1;
`endif

  assign pc_inc    = pc_q + 1'b1;
  assign rd_addr   = (state_q == HOLD) ? pc_inc[AW-1:0] : '0;
  assign rd_cls    = rd_data[INSTR_WIDTH-1 -: 2];
  assign cur_cls   = instr_q[INSTR_WIDTH-1 -: 2];
  assign len_clamp = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign mem_we    = prog_we & ((state_q == IDLE) | (state_q == FINISH));

  instr_prog_mem #(
    .W  (INSTR_WIDTH),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // next-state: launch, lead-in, per-class hold, run end
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    halted_d = halted_q;
    pc_d     = pc_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    fin      = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_d = '0;
        if (start) begin
          halted_d = 1'b0;
          if (len_clamp == '0) begin
            fin = 1'b1;
          end else begin
            instr_d = rd_data;
            pc_d    = '0;
            len_d   = len_clamp;
            busy_d  = 1'b1;
            if (LEAD_CYCLES > 0) begin
              cnt_d   = CNT_W'(LEAD_CYCLES - 1);
              state_d = LEAD;
            end else if (rd_cls == CLS_HALT) begin
              halted_d = 1'b1;
              fin      = 1'b1;
            end else begin
              cnt_d   = CNT_W'(slot_cycles(rd_cls, STD_CYCLES, MEM_CYCLES) - 1);
              state_d = HOLD;
            end
          end
        end
      end
      LEAD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (cur_cls == CLS_HALT) begin
          halted_d = 1'b1;
          fin      = 1'b1;
        end else begin
          cnt_d   = CNT_W'(slot_cycles(cur_cls, STD_CYCLES, MEM_CYCLES) - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (adv) begin
          pc_d = pc_inc;
          if (pc_inc == len_q) begin
            fin = 1'b1;
          end else if (rd_cls == CLS_HALT) begin
            halted_d = 1'b1;
            fin      = 1'b1;
          end else begin
            instr_d = rd_data;
            cnt_d   = CNT_W'(slot_cycles(rd_cls, STD_CYCLES, MEM_CYCLES) - 1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = FINISH;
      instr_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      halted_q <= halted_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  assign instruction = instr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halted      = halted_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed cases plus random programs
// against a per-cycle trace model built from the class slot rules.
module tb_instr_sequencer;

  localparam int STD_C  = 3;
  localparam int MEM_C  = 4;
  localparam int LEAD_C = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [19:0] prog_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        step;
  logic [19:0] instruction;
  logic        busy;
  logic        done;
  logic        halted;
  logic [4:0]  pc;

  int n_chk = 0;
  int n_err = 0;

  logic [19:0] mem_m [16];
  logic        halted_m;
  logic [19:0] exp_instr [$];
  int          exp_pc [$];

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .step        (step),
    .instruction (instruction),
    .busy        (busy),
    .done        (done),
    .halted      (halted),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [19:0] w);
    return (w[19:18] == 2'b01) ? STD_C : MEM_C;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    step = 1'($urandom);
  endtask

  task automatic write_word(input int a, input logic [19:0] d);
    prog_we   = 1'b1;
    prog_addr = 4'(a);
    prog_data = d;
    mem_m[a]  = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic run(input string tag, input int len, input bit inj,
                     input int abort_at, input bit wr0,
                     input logic [19:0] wr0_data);
    logic [19:0] snap [16];
    int eff;
    bit hit;
    logic [19:0] w;
    snap = mem_m;
    eff = (len > 16) ? 16 : len;
    hit = 1'b0;
    exp_instr.delete();
    exp_pc.delete();
    for (int i = 0; i < eff; i++) begin
      w = snap[i];
      if (i == 0)
        for (int j = 0; j < LEAD_C; j++) begin
          exp_instr.push_back(w);
          exp_pc.push_back(0);
        end
      if (w[19:18] == 2'b00) begin
        hit = 1'b1;
        break;
      end
      for (int j = 0; j < slot_of(w); j++) begin
        exp_instr.push_back(w);
        exp_pc.push_back(i);
      end
    end
    prog_len = 5'(len);
    start    = 1'b1;
    if (wr0) begin
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = wr0_data;
      mem_m[0]  = wr0_data;
    end
    tick();
    start   = 1'b0;
    prog_we = 1'b0;
    for (int k = 0; k < exp_instr.size(); k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, " rst_instr"}, instruction, 20'h0);
        chk({tag, " rst_busy"}, busy, 1'b0);
        chk({tag, " rst_pc"}, pc, 5'd0);
        chk({tag, " rst_done"}, done, 1'b0);
        tick();
        chk({tag, " rst_nodone"}, done, 1'b0);
        halted_m = 1'b0;
        return;
      end
      chk({tag, " instr"}, instruction, exp_instr[k]);
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " done"}, done, 1'b0);
      chk({tag, " pc"}, pc, 5'(exp_pc[k]));
      chk({tag, " halted_lo"}, halted, 1'b0);
      if (inj && k == 2) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = ~snap[1];
      end
      tick();
      start   = 1'b0;
      prog_we = 1'b0;
    end
    halted_m = hit;
    chk({tag, " end_done"}, done, 1'b1);
    chk({tag, " end_busy"}, busy, 1'b0);
    chk({tag, " end_instr"}, instruction, 20'h0);
    chk({tag, " end_halted"}, halted, halted_m);
    tick();
    chk({tag, " idle_done"}, done, 1'b0);
    chk({tag, " idle_busy"}, busy, 1'b0);
    chk({tag, " idle_instr"}, instruction, 20'h0);
    chk({tag, " idle_halted"}, halted, halted_m);
  endtask

  initial begin
    logic [19:0] w;
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    step      = 1'b0;
    halted_m  = 1'b0;
    tick();
    tick();
    chk("reset_instr", instruction, 20'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_pc", pc, 5'd0);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) write_word(a, 20'h40000 | 20'(a));

    write_word(0, 20'h41203);
    write_word(1, 20'h94050);
    write_word(2, 20'hD4060);
    run("basic", 3, 1'b0, -1, 1'b0, '0);
    run("len0", 0, 1'b0, -1, 1'b0, '0);
    run("inject", 3, 1'b1, -1, 1'b0, '0);
    run("midrst", 3, 1'b0, 5, 1'b0, '0);
    run("replay", 3, 1'b0, -1, 1'b0, '0);
    run("wr_start", 3, 1'b0, -1, 1'b1, 20'h52222);
    run("after_wr", 3, 1'b0, -1, 1'b0, '0);

    write_word(1, 20'h00000);
    run("halt_mid", 3, 1'b0, -1, 1'b0, '0);
    write_word(0, 20'h01234);
    run("halt_pc0", 3, 1'b0, -1, 1'b0, '0);
    run("clr_halt", 0, 1'b0, -1, 1'b0, '0);

    for (int a = 0; a < 16; a++) write_word(a, 20'hC0000 | 20'(a));
    run("full16", 16, 1'b0, -1, 1'b0, '0);
    run("clamp31", 31, 1'b0, -1, 1'b0, '0);

    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 16; a++) begin
        w = 20'($urandom);
        if ($urandom_range(0, 9) != 0 && w[19:18] == 2'b00) w[18] = 1'b1;
        write_word(a, w);
      end
      run("rand", $urandom_range(0, 31), 1'b0, -1, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
